// File: rtl/lenia_growth_update.sv
// Lenia growth/update stage: maps potential U and cell A to A' through a
// 3-stage pipeline, with frame bookkeeping (out_last, frame_done, population).
module lenia_growth_update #(
    parameter int          SIZE      = 32,
    parameter int          FRAC      = 16,
    parameter logic [31:0] MU        = 32'h0000_4000,
    parameter logic [31:0] SIGMA_INV = 32'h0004_0000,
    parameter int          DT_SHIFT  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_potential,
    input  logic [31:0] in_cell,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_cell,
    output logic        out_last,
    output logic        frame_done,
    output logic [31:0] population
);

    localparam logic [33:0] ONE    = 34'd1 << FRAC;
    localparam logic [33:0] TWO    = ONE << 1;
    localparam int          NCELLS = SIZE * SIZE;
    localparam int          CW     = (NCELLS > 1) ? $clog2(NCELLS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NCELLS - 1);

    logic               v1_q, v2_q, v3_q;
    logic [31:0]        d1_q, a1_q, a2_q, out_cell_q;
    logic signed [33:0] g2_q;
    logic [CW-1:0]      cnt_q;
    logic [31:0]        run_q, pop_q;
    logic               done_q;

    logic               enable, xfer, last, nz;
    logic [31:0]        d1_d, a1_d, cell_d;
    logic [63:0]        prod, shifted;
    logic [33:0]        t2;
    logic signed [33:0] g2_d;
    logic signed [35:0] gs, sum;

    assign enable = !v3_q || out_ready;
    assign xfer   = v3_q && out_ready;
    assign last   = v3_q && (cnt_q == LAST_IDX);
    assign nz     = (out_cell_q != 32'd0);

    // S1: distance from the growth centre; cell pre-clamped to ONE
    always_comb begin
        d1_d = (in_potential >= MU) ? (in_potential - MU) : (MU - in_potential);
        a1_d = (in_cell > ONE[31:0]) ? ONE[31:0] : in_cell;
    end

    // S2: triangular growth g = ONE - min(d*sigma_inv, 2*ONE)
    always_comb begin
        prod    = 64'(d1_q) * 64'(SIGMA_INV);
        shifted = prod >> FRAC;
        t2      = (shifted > 64'(TWO)) ? TWO : shifted[33:0];
        g2_d    = $signed(ONE - t2);
    end

    // S3: Euler step with saturation to [0, ONE]
    always_comb begin
        gs  = $signed({{2{g2_q[33]}}, g2_q}) >>> DT_SHIFT;
        sum = $signed({4'b0000, a2_q}) + gs;
        if (sum < 36'sd0) begin
            cell_d = 32'd0;
        end else if (sum > $signed({2'b00, ONE})) begin
            cell_d = ONE[31:0];
        end else begin
            cell_d = sum[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            d1_q       <= '0;
            a1_q       <= '0;
            a2_q       <= '0;
            g2_q       <= '0;
            out_cell_q <= '0;
            cnt_q      <= '0;
            run_q      <= '0;
            pop_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            if (enable) begin
                v1_q       <= in_valid;
                v2_q       <= v1_q;
                v3_q       <= v2_q;
                d1_q       <= d1_d;
                a1_q       <= a1_d;
                a2_q       <= a1_q;
                g2_q       <= g2_d;
                out_cell_q <= cell_d;
            end
            done_q <= xfer && last;
            if (xfer) begin
                if (last) begin
                    cnt_q <= '0;
                    pop_q <= run_q + 32'(nz);
                    run_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                    run_q <= run_q + 32'(nz);
                end
            end
        end
    end

    assign in_ready   = enable;
    assign out_valid  = v3_q;
    assign out_cell   = out_cell_q;
    assign out_last   = last;
    assign frame_done = done_q;
    assign population = pop_q;

endmodule

// File: tb/tb_lenia_growth_update.sv
// Directed bench for lenia_growth_update: hand-computed cells, stalls,
// frame accounting and mid-frame reset.
module tb_lenia_growth_update;

    localparam int NC = 1024;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic        out_last, frame_done;
    logic [31:0] in_potential, in_cell, out_cell, population;

    int errors = 0;
    int checks = 0;

    logic [31:0] q[$];
    int          fcnt = 0, nzc = 0, lasts = 0, xfers = 0;
    logic [31:0] exp_pop = 0;
    logic        pend_done = 0;

    always #5 clk = ~clk;

    lenia_growth_update dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_potential(in_potential), .in_cell(in_cell),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cell(out_cell), .out_last(out_last),
        .frame_done(frame_done), .population(population)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] u,
                                          input logic [31:0] a);
        longint d, t, g, r, ac;
        logic [63:0] rv;
        d  = (u >= 32'h4000) ? longint'(u) - 64'h4000 : 64'h4000 - longint'(u);
        t  = (d * 64'h40000) >>> 16;
        if (t > 131072) t = 131072;
        g  = 65536 - t;
        ac = (a > 32'h10000) ? 65536 : longint'(a);
        r  = ac + (g >>> 3);
        if (r < 0) r = 0;
        if (r > 65536) r = 65536;
        rv = r;
        return rv[31:0];
    endfunction

    task automatic send(input logic [31:0] u, input logic [31:0] a,
                        input logic [31:0] e);
        int n = 0;
        logic acc = 1'b0;
        in_valid = 1'b1;
        in_potential = u;
        in_cell = a;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (acc) q.push_back(e);
        else chk("accept_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", q.size(), 32'd0);
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Scoreboard: order, out_last placement, frame_done timing, population
    always @(negedge clk) begin
        logic [31:0] e;
        if (reset) begin
            q.delete();
            fcnt = 0;
            nzc = 0;
            exp_pop = 0;
            pend_done = 1'b0;
        end else begin
            chk("frame_done", {31'd0, frame_done}, {31'd0, pend_done});
            pend_done = 1'b0;
            chk("population", population, exp_pop);
            if (out_valid)
                chk("out_last", {31'd0, out_last}, {31'd0, fcnt == NC - 1});
            if (out_valid && out_ready) begin
                chk("sb_nonempty", {31'd0, q.size() != 0}, 32'd1);
                e = (q.size() != 0) ? q.pop_front() : 32'hDEAD_BEEF;
                chk("cell", out_cell, e);
                if (e != 0) nzc++;
                xfers++;
                if (fcnt == NC - 1) begin
                    pend_done = 1'b1;
                    exp_pop = nzc;
                    fcnt = 0;
                    nzc = 0;
                    lasts++;
                end else begin
                    fcnt++;
                end
            end
        end
    end

    logic [31:0] du[10] = '{32'h4000, 32'h6000, 32'hC000, 32'h4000, 32'h4000,
                           32'h0, 32'h5000, 32'h3000, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] da[10] = '{32'h0, 32'h1000, 32'h1000, 32'hF000, 32'h20000,
                           32'h7777, 32'h8000, 32'h0, 32'h10000, 32'h0};
    logic [31:0] de[10] = '{32'h2000, 32'h2000, 32'h0, 32'h10000, 32'h10000,
                           32'h7777, 32'h9800, 32'h1800, 32'hE000, 32'h0};

    initial begin
        logic [31:0] u, a;
        reset = 1'b1;
        in_valid = 1'b0;
        in_potential = '0;
        in_cell = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_cell", out_cell, 32'd0);
        chk("rst_population", population, 32'd0);
        @(posedge clk);
        #1;

        // Latency: valid appears on the third edge after acceptance
        send(32'h4000, 32'h0, 32'h2000);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat3", {31'd0, out_valid}, 32'd1);
        chk("lat3_cell", out_cell, 32'h2000);
        drain();

        for (int i = 0; i < 10; i++) send(du[i], da[i], de[i]);
        in_valid = 1'b0;
        drain();

        // Back-to-back stream with a 5-cycle consumer stall
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    u = 32'h3000 + i * 32'h400;
                    a = i * 32'h800;
                    send(u, a, model(u, a));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_held", q.size(), 32'd3);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Full frame, 100 zero-producing cells
        pulse_reset();
        lasts = 0;
        xfers = 0;
        for (int i = 0; i < NC; i++) begin
            if (i % 10 == 3 && i < 1000) send(32'h0, 32'h0, 32'h0);
            else begin
                a = (i * 37) & 32'hFFFF;
                send(32'h4000, a, model(32'h4000, a));
            end
        end
        in_valid = 1'b0;
        drain();
        @(negedge clk);
        chk("frame_pop", population, 32'd924);
        chk("frame_lasts", lasts, 32'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) send(32'h4000, 32'h100, 32'h2100);
        in_valid = 1'b0;
        drain();
        chk("next_frame_cnt", fcnt, 32'd5);
        chk("pop_held", population, 32'd924);

        // Reset with the pipeline full after 500 transfers
        xfers = 0;
        lasts = 0;
        for (int i = 0; i < 600 && xfers < 500; i++) begin
            u = 32'h2000 + i * 32'h40;
            send(u, 32'h1000, model(u, 32'h1000));
        end
        chk("pre_reset_xfers", xfers, 32'd500);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_population", population, 32'd0);
        chk("mr_out_last", {31'd0, out_last}, 32'd0);
        chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        xfers = 0;
        lasts = 0;
        for (int i = 0; i < NC; i++) begin
            u = i * 32'h97;
            a = (i * 32'h131) & 32'h1FFFF;
            send(u, a, model(u, a));
        end
        in_valid = 1'b0;
        drain();
        chk("mr_xfers", xfers, 32'd1024);
        chk("mr_lasts", lasts, 32'd1);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lenia_growth_update.md
LENIA_GROWTH_UPDATE -- requirements
Module: lenia_growth_update

Interface
REQ-001 SHALL have parameter SIZE, default 32: world edge length; one frame is SIZE*SIZE cells.
REQ-002 SHALL have parameter FRAC, default 16: fractional bits of all Q-format values (ONE = 2^FRAC).
REQ-003 SHALL have parameter MU, default 32'h0000_4000: growth centre, unsigned Q16.16.
REQ-004 SHALL have parameter SIGMA_INV, default 32'h0004_0000: reciprocal growth width, unsigned Q16.16.
REQ-005 SHALL have parameter DT_SHIFT, default 3: time step dt = 2^-DT_SHIFT.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port in_valid  input  1  potential/cell pair offered.
REQ-009 SHALL have port in_ready  output  1  pair accepted when in_valid && in_ready.
REQ-010 SHALL have port in_potential  input  32  convolution result U, unsigned Q16.16.
REQ-011 SHALL have port in_cell  input  32  current cell state A, unsigned Q16.16.
REQ-012 SHALL have port out_valid  output  1  updated cell available.
REQ-013 SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-014 SHALL have port out_cell  output  32  updated cell A', unsigned Q16.16 in [0, ONE].
REQ-015 SHALL have port out_last  output  1  out_cell is the final cell of the frame.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse after the final cell of a frame is transferred.
REQ-017 SHALL have port population  output  32  count of nonzero out_cell values in the last completed frame.

Function
REQ-018 SHALL compute, per pair: d = |U - MU|; t = min((d * SIGMA_INV) >> FRAC, 2*ONE) using a 64-bit product; g = ONE - t (signed, range [-ONE, ONE]).
REQ-019 SHALL compute A' = clamp(min(A, ONE) + (g >>> DT_SHIFT), 0, ONE), using arithmetic shift and at least 34-bit signed intermediate so that no wrap occurs.
REQ-020 SHALL be a 3-stage pipeline (S1: d; S2: t, g; S3: A'), each stage with its own valid bit.
REQ-021 SHALL advance all stages together when enable = !out_valid || out_ready; in_ready SHALL equal enable (combinational).
REQ-022 SHALL present out_valid exactly 3 cycles after acceptance when enable stays high; throughput one pair per cycle.
REQ-023 SHALL hold out_cell, out_last and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL preserve input order; no pair dropped or duplicated under any stall pattern.
REQ-025 SHALL count output transfers in a cell counter 0..SIZE*SIZE-1; out_last SHALL be high iff out_valid and counter == SIZE*SIZE-1.
REQ-026 SHALL, on the transfer with out_last, wrap the counter to 0, latch population = running nonzero count including that cell, clear the running count, and pulse frame_done high in the following cycle only.
REQ-027 SHALL hold population constant between frame ends.
REQ-028 SHALL treat in_cell > ONE as ONE; MU and U compared as unsigned.

Reset
REQ-029 SHALL, while reset is high at a clock edge, clear all stage valid bits, the cell counter and the running count; out_valid=0, out_cell=0, out_last=0, frame_done=0, population=0.
REQ-030 SHALL discard in-flight pairs on reset mid-frame; the next accepted pair after reset starts a new frame at counter 0.
REQ-031 SHALL drive in_ready=1 in the first cycle after reset is released.

Verification
REQ-032 Defaults, U=0x4000, A=0x0000, out_ready=1 -> out_cell=0x2000 three cycles after acceptance.
REQ-033 U=0x6000, A=0x1000 -> t=0x8000, g=0x8000, out_cell=0x2000; U=0xC000, A=0x1000 -> g=-0x10000, out_cell=0x0000 (floor clamp).
REQ-034 U=0x4000, A=0xF000 -> out_cell=0x10000 (ceiling clamp); A=0x20000 input -> treated as 0x10000, out_cell=0x10000.
REQ-035 Back-to-back inputs, out_ready low 5 cycles mid-stream -> in_ready low while stalled with 3 pairs held, all outputs delivered in order, none lost or repeated.
REQ-036 1024 pairs (SIZE=32), 100 yielding zero -> out_last only on the 1024th transfer, single frame_done pulse the next cycle, population=924, next frame counter restarts at 0.
REQ-037 Reset asserted after 500 transfers with pipeline full -> out_valid=0 next cycle, population=0, following 1024 pairs produce exactly one out_last at transfer 1024.
